stopwatch_ctrl: RTL and testbench

Run/stop/lap/reset controller for the stopwatch digit chain. Takes two raw push-buttons (start/stop and lap/reset), synchronizes and debounces them, and runs a four-state control FSM. Drives the digit counters with a single-cycle base tick, a clear pulse and a display-hold flag, so the counters never see raw button levels or free-running divided clocks. Sits between the board buttons and the stopwatch counter/display datapath, in the `clk` domain.

---
 rtl/stopwatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sync/debounce two buttons, run/stop/lap/reset FSM, base-tick prescaler.
// Ports: clk, reset (async, active-low), btn_ss/btn_lr raw buttons in;
//        tick, clr, hold, running, state[1:0] out, all straight from flops.

module stopwatch_btn_stage #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          db;
  logic          db_q;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      db_q  <= db;
      press <= db & ~db_q;
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } st_t;

  st_t           cur;
  st_t           nxt;
  logic          ss_p;
  logic          lr_p;
  logic          ss_go;
  logic          lr_go;
  logic          clr_d;
  logic          hold_d;
  logic          run_d;
  logic          active;
  logic          wrap;
  logic [PW-1:0] presc;

  stopwatch_btn_stage #(.DB_CYCLES(DB_CYCLES)) u_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_ss),
    .press (ss_p)
  );

  stopwatch_btn_stage #(.DB_CYCLES(DB_CYCLES)) u_lr (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lr),
    .press (lr_p)
  );

  // start/stop has priority when both presses land together
  assign ss_go = ss_p;
  assign lr_go = lr_p & ~ss_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur     <= IDLE;
      clr     <= 1'b0;
      hold    <= 1'b0;
      running <= 1'b0;
    end else begin
      cur     <= nxt;
      clr     <= clr_d;
      hold    <= hold_d;
      running <= run_d;
    end
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:  if (ss_go) nxt = RUN;
      RUN:   if (ss_go) nxt = PAUSE;
             else if (lr_go) nxt = LAP;
      LAP:   if (ss_go) nxt = PAUSE;
             else if (lr_go) nxt = RUN;
      PAUSE: if (ss_go) nxt = RUN;
             else if (lr_go) nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_d  = 1'b0;
    hold_d = 1'b0;
    run_d  = 1'b0;
    unique case (1'b1)
      (cur == IDLE):  clr_d = lr_go;
      (cur == PAUSE): clr_d = lr_go;
      default:        clr_d = 1'b0;
    endcase
    hold_d = (nxt == LAP);
    run_d  = (nxt == RUN) || (nxt == LAP);
  end

  assign state  = cur;
  assign active = (cur == RUN) || (cur == LAP);
  assign wrap   = active && (presc == P_LAST);

  // PAUSE keeps the fraction; the leaving edge may still wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (cur == IDLE) begin
        presc <= '0;
      end else if (active) begin
        presc <= wrap ? '0 : presc + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus with queued expectations.
// Monitor pops tick, clr and state-change events and compares cycles/values.

module tb_stopwatch_ctrl;
  localparam int TD = 5;
  localparam int DB = 3;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       tick;
  logic       clr;
  logic       hold;
  logic       running;
  logic [1:0] state;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       h;
    logic       r;
  } sev_t;

  sev_t st_q[$];
  int   tick_q[$];
  int   clr_q[$];

  stopwatch_ctrl #(
    .TICK_DIV  (TD),
    .DB_CYCLES (DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .tick    (tick),
    .clr     (clr),
    .hold    (hold),
    .running (running),
    .state   (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void exp_state(input int c, input logic [1:0] s,
                                    input logic h, input logic r);
    sev_t e;
    e.cyc = c;
    e.st  = s;
    e.h   = h;
    e.r   = r;
    st_q.push_back(e);
  endfunction

  task automatic monitor();
    logic [3:0] prev;
    logic [3:0] now_v;
    sev_t       e;
    int         ec;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = '0;
        continue;
      end
      if (tick) begin
        if (tick_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tick_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          ec = tick_q.pop_front();
          chk("tick_cycle", cyc, ec);
        end
      end
      if (clr) begin
        if (clr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL clr_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          ec = clr_q.pop_front();
          chk("clr_cycle", cyc, ec);
          chk("clr_tick", int'(tick), 0);
          chk("clr_state", int'(state), 0);
        end
      end
      now_v = {state, hold, running};
      if (now_v != prev) begin
        if (st_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL state_unexpected: got state=%0d hold=%0d running=%0d at cycle %0d, expected no change",
                   state, hold, running, cyc);
        end else begin
          e = st_q.pop_front();
          chk("state_cycle", cyc, e.cyc);
          chk("state_val", int'(state), int'(e.st));
          chk("state_hold", int'(hold), int'(e.h));
          chk("state_running", int'(running), int'(e.r));
        end
        prev = now_v;
      end
    end
  endtask

  task automatic press_at(input int k, input logic ss, input logic lr,
                          input int len);
    if (cyc > k - 1) begin
      checks++;
      failures++;
      $display("FAIL schedule: got cycle %0d, expected <= %0d", cyc, k - 1);
    end
    while (cyc < k - 1) @(negedge clk);
    btn_ss = ss;
    btn_lr = lr;
    repeat (len) @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  initial begin
    int b;
    int k;
    int n;
    fork
      monitor();
    join_none

    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_clr", int'(clr), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_running", int'(running), 0);
    @(negedge clk);
    #2 reset = 1'b1;

    @(negedge clk);
    repeat (10) begin
      btn_ss = 1'b1;
      repeat (2) @(negedge clk);
      btn_ss = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("glitch_state", int'(state), 0);

    b = cyc;
    exp_state(b + 8, 2'b01, 1'b0, 1'b1);
    for (int t = b + 13; t <= b + 33; t += 5) tick_q.push_back(t);
    exp_state(b + 35, 2'b11, 1'b0, 1'b0);
    exp_state(b + 91, 2'b01, 1'b0, 1'b1);
    for (int t = b + 94; t <= b + 124; t += 5) tick_q.push_back(t);
    exp_state(b + 107, 2'b10, 1'b1, 1'b1);
    exp_state(b + 125, 2'b11, 1'b0, 1'b0);
    exp_state(b + 143, 2'b00, 1'b0, 1'b0);
    clr_q.push_back(b + 143);
    clr_q.push_back(b + 161);
    exp_state(b + 179, 2'b01, 1'b0, 1'b1);
    for (int t = b + 184; t <= b + 194; t += 5) tick_q.push_back(t);
    exp_state(b + 197, 2'b11, 1'b0, 1'b0);
    exp_state(b + 215, 2'b01, 1'b0, 1'b1);
    for (int t = b + 217; t <= b + 227; t += 5) tick_q.push_back(t);
    exp_state(b + 227, 2'b11, 1'b0, 1'b0);
    exp_state(b + 245, 2'b00, 1'b0, 1'b0);
    clr_q.push_back(b + 245);
    exp_state(b + 263, 2'b01, 1'b0, 1'b1);
    tick_q.push_back(b + 268);
    tick_q.push_back(b + 273);

    press_at(b + 2,   1'b1, 1'b0, 20);
    press_at(b + 29,  1'b1, 1'b0, 6);
    press_at(b + 85,  1'b1, 1'b0, 6);
    press_at(b + 101, 1'b0, 1'b1, 6);
    press_at(b + 119, 1'b1, 1'b0, 6);
    press_at(b + 137, 1'b0, 1'b1, 6);
    press_at(b + 155, 1'b0, 1'b1, 6);
    press_at(b + 173, 1'b1, 1'b0, 6);
    press_at(b + 191, 1'b1, 1'b1, 6);
    press_at(b + 209, 1'b1, 1'b0, 6);
    press_at(b + 221, 1'b1, 1'b0, 6);
    press_at(b + 239, 1'b0, 1'b1, 6);
    press_at(b + 257, 1'b1, 1'b0, 6);

    while (cyc < b + 275) @(negedge clk);
    chk("run_before_rst", int'(running), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_tick", int'(tick), 0);
    chk("async_clr", int'(clr), 0);
    chk("async_hold", int'(hold), 0);
    chk("async_running", int'(running), 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick) n++;
    end
    chk("idle_ticks", n, 0);
    chk("idle_state", int'(state), 0);

    #2 reset = 1'b0;
    btn_ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    k = cyc + 1;
    exp_state(k + 6, 2'b01, 1'b0, 1'b1);
    tick_q.push_back(k + 11);
    while (cyc < k + 9) @(negedge clk);
    btn_ss = 1'b0;
    while (cyc < k + 13) @(negedge clk);

    while (st_q.size() > 0) begin
      sev_t e;
      e = st_q.pop_front();
      checks++;
      failures++;
      $display("FAIL state_missing: got no change, expected state=%0d at cycle %0d",
               e.st, e.cyc);
    end
    while (tick_q.size() > 0) begin
      int t;
      t = tick_q.pop_front();
      checks++;
      failures++;
      $display("FAIL tick_missing: got no pulse, expected pulse at cycle %0d", t);
    end
    while (clr_q.size() > 0) begin
      int t;
      t = clr_q.pop_front();
      checks++;
      failures++;
      $display("FAIL clr_missing: got no pulse, expected pulse at cycle %0d", t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
